// File: rtl/data_memory_hs.sv
// Word-organised data memory with valid/ready request and response channels.
// Handles byte/half/word loads and stores, programmable read latency and access errors.
module data_memory_hs #(
    parameter int XLEN         = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_sign_ext_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic              accept;
    logic [XLEN-3:0]   word_addr;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic              req_err;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   load_data;
    logic [3:0]        strb;
    logic [XLEN-1:0]   wdata_lane;
    logic              mem_we;

    assign accept    = req_valid_i && (state_q == ST_IDLE);
    assign word_addr = req_addr_i[XLEN-1:2];
    assign idx       = req_addr_i[AW+1:2];
    assign lane      = req_addr_i[1:0];

    // Request decode: error detection, lane steering and load extension.
    always_comb begin
        req_err    = 1'b0;
        strb       = 4'b0000;
        wdata_lane = req_wdata_i;
        load_data  = '0;
        rd_word    = mem_q[idx];
        rd_shift   = rd_word >> {lane, 3'b000};

        if (word_addr >= (XLEN-2)'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end

        unique case (req_size_i)
            SZ_BYTE: begin
                strb       = 4'b0001 << lane;
                wdata_lane = {4{req_wdata_i[7:0]}};
                load_data  = {{(XLEN-8){req_sign_ext_i & rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_HALF: begin
                if (lane[0]) req_err = 1'b1;
                strb       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata_i[15:0]}};
                load_data  = {{(XLEN-16){req_sign_ext_i & rd_shift[15]}}, rd_shift[15:0]};
            end
            SZ_WORD: begin
                if (lane != 2'b00) req_err = 1'b1;
                strb       = 4'b1111;
                load_data  = rd_shift;
            end
            SZ_ILL: begin
                req_err = 1'b1;
            end
            default: req_err = 1'b1;
        endcase

        mem_we = accept && req_we_i && !req_err;
    end

    // NOTE: the memory array has no reset; stored data must survive rst_ni and
    // a reset port would prevent mapping onto RAM macros.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && strb[b]) begin
                mem_q[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // NOTE: state flops use non-blocking assignments only; combinational
    // processes below assign every output a default first so no latch is inferred.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d   = req_err;
                    rdata_d = (req_we_i || req_err) ? '0 : load_data;
                    if (!req_we_i && !req_err && (READ_LATENCY > 1)) begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(READ_LATENCY - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);
        rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
        rsp_err_o   = rsp_valid_o && err_q;
    end

endmodule
